snn_spi_config_loader: RTL and testbench

Serial configuration front end for the spiking neuron network. It accepts SPI mode-0 frames from an off-chip host, assembles them into address/data pairs, and drives the network's parameter register-file write port (`addr`, `data_in`, `write_enable`) with single-cycle write pulses. It is the initiator side of that write interface and sits between the chip's serial pins and the network's configuration inputs.

---
 rtl/snn_spi_config_loader.sv | 147 ++++++++++++++
 tb/tb_snn_spi_config_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/snn_spi_config_loader.sv
// snn_spi_config_loader: SPI mode-0 frames (4b addr + 8b data, MSB first) to register-file write pulses.
// Define SNN_CFG_AUTO_INC_EN for burst mode (further bytes go to addr+1, 4-bit wrap).
module snn_spi_config_loader (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       sck,
   input  logic       mosi,
   output logic [3:0] cfg_addr,
   output logic [7:0] cfg_data,
   output logic       cfg_we,
   output logic       busy,
   output logic       frame_err,
   output logic [7:0] write_count
);
   localparam logic [2:0] ARM   = 3'd0;
   localparam logic [2:0] IDLE  = 3'd1;
   localparam logic [2:0] ADDR  = 3'd2;
   localparam logic [2:0] DATA  = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;
   localparam logic [2:0] HOLD  = 3'd5;
   logic [1:0] cs_s_q, cs_s_d, mosi_s_q, mosi_s_d;
   logic [2:0] sck_s_q, sck_s_d;
   logic [2:0] state_q, state_d, cnt_q, cnt_d;
   logic [3:0] addr_sr_q, addr_sr_d, cfg_addr_q, cfg_addr_d;
   logic [7:0] data_sr_q, data_sr_d, cfg_data_q, cfg_data_d;
   logic [7:0] write_count_q, write_count_d;
   logic       cfg_we_q, cfg_we_d, frame_err_q, frame_err_d;
   logic       cs_hi, sck_rise, bit_in, data_abort_err;
`ifdef SNN_CFG_AUTO_INC_EN
   logic       burst_q, burst_d;
   assign data_abort_err = (cnt_q != 3'd0) || !burst_q;
`else
   assign data_abort_err = 1'b1;
`endif
   assign cs_hi    = cs_s_q[1];
   assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
   assign bit_in   = mosi_s_q[1];
   always_comb begin
      cs_s_d        = {cs_s_q[0], cs_n};
      sck_s_d       = {sck_s_q[1:0], sck};
      mosi_s_d      = {mosi_s_q[0], mosi};
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_sr_d     = addr_sr_q;
      data_sr_d     = data_sr_q;
      cfg_addr_d    = cfg_addr_q;
      cfg_data_d    = cfg_data_q;
      write_count_d = write_count_q;
      cfg_we_d      = 1'b0;
      frame_err_d   = 1'b0;
`ifdef SNN_CFG_AUTO_INC_EN
      burst_d       = burst_q;
`endif
      case (state_q)
         // Leave ARM only once the synchronizer holds post-reset samples, so a frame in flight is dropped.
         ARM: begin
            cnt_d   = (cnt_q == 3'd2) ? cnt_q : cnt_q + 3'd1;
            state_d = (cnt_q == 3'd2 && cs_hi) ? IDLE : ARM;
         end
         IDLE: begin
            cnt_d   = 3'd0;
            state_d = cs_hi ? IDLE : ADDR;
`ifdef SNN_CFG_AUTO_INC_EN
            burst_d = 1'b0;
`endif
         end
         ADDR: begin
            if (sck_rise) begin
               addr_sr_d = {addr_sr_q[2:0], bit_in};
               cnt_d     = (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
               state_d   = (cnt_q == 3'd3) ? DATA : ADDR;
            end else if (cs_hi) begin
               state_d     = IDLE;
               frame_err_d = cnt_q != 3'd0;
            end
         end
         DATA: begin
            if (sck_rise) begin
               data_sr_d = {data_sr_q[6:0], bit_in};
               cnt_d     = cnt_q + 3'd1;
               state_d   = (cnt_q == 3'd7) ? WRITE : DATA;
            end else if (cs_hi) begin
               state_d     = IDLE;
               frame_err_d = data_abort_err;
            end
         end
         WRITE: begin
            cfg_we_d      = 1'b1;
            cfg_addr_d    = addr_sr_q;
            cfg_data_d    = data_sr_q;
            write_count_d = (write_count_q == 8'hFF) ? write_count_q : write_count_q + 8'd1;
            state_d       = cs_hi ? IDLE : HOLD;
`ifdef SNN_CFG_AUTO_INC_EN
            if (!cs_hi) begin
               state_d   = DATA;
               addr_sr_d = addr_sr_q + 4'd1;
               burst_d   = 1'b1;
            end
`endif
         end
         HOLD: state_d = cs_hi ? IDLE : HOLD;
         default: state_d = ARM;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_s_q        <= 2'b11;
         sck_s_q       <= 3'b000;
         mosi_s_q      <= 2'b00;
         state_q       <= ARM;
         cnt_q         <= 3'd0;
         addr_sr_q     <= 4'd0;
         data_sr_q     <= 8'd0;
         cfg_addr_q    <= 4'd0;
         cfg_data_q    <= 8'd0;
         write_count_q <= 8'd0;
         cfg_we_q      <= 1'b0;
         frame_err_q   <= 1'b0;
`ifdef SNN_CFG_AUTO_INC_EN
         burst_q       <= 1'b0;
`endif
      end else begin
         cs_s_q        <= cs_s_d;
         sck_s_q       <= sck_s_d;
         mosi_s_q      <= mosi_s_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_sr_q     <= addr_sr_d;
         data_sr_q     <= data_sr_d;
         cfg_addr_q    <= cfg_addr_d;
         cfg_data_q    <= cfg_data_d;
         write_count_q <= write_count_d;
         cfg_we_q      <= cfg_we_d;
         frame_err_q   <= frame_err_d;
`ifdef SNN_CFG_AUTO_INC_EN
         burst_q       <= burst_d;
`endif
      end
   end
   assign cfg_addr    = cfg_addr_q;
   assign cfg_data    = cfg_data_q;
   assign cfg_we      = cfg_we_q;
   assign frame_err   = frame_err_q;
   assign write_count = write_count_q;
   assign busy        = (state_q != IDLE) && (state_q != ARM);
endmodule

// File: tb/tb_snn_spi_config_loader.sv
// tb_snn_spi_config_loader: directed SPI frames checked against a queue-based write/error model.
module tb_snn_spi_config_loader;
   logic       clk = 1'b0, reset = 1'b1, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_data, write_count;
   logic       cfg_we, busy, frame_err;
   int         total = 0, bad = 0;
   logic [11:0] exp_q[$];
   int         err_m = 0, wc_m = 0, lat;
   logic [3:0] la = 4'd0;
   logic [7:0] ld = 8'd0;
   logic       prev_we = 1'b0;
   snn_spi_config_loader dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .sck(sck), .mosi(mosi),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we), .busy(busy),
      .frame_err(frame_err), .write_count(write_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, req);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         cyc(3);
         sck = 1'b1;
         cyc(3);
         sck = 1'b0;
      end
   endtask
   task automatic frame(input logic [3:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
      cs_n = 1'b0;
      cyc(3);
      send_bits({20'd0, a, d}, 12);
      cyc(3);
      cs_n = 1'b1;
      cyc(5);
   endtask
   // Scoreboard: every write must match the next expected pair; outputs hold between writes.
   always @(negedge clk) begin
      if (reset) begin
         wc_m = 0; la = 4'd0; ld = 8'd0; prev_we = 1'b0;
      end else begin
         if (cfg_we) begin
            chk("we_back_to_back", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
               {la, ld} = exp_q.pop_front();
               chk("write_addr", {28'd0, cfg_addr}, {28'd0, la});
               chk("write_data", {24'd0, cfg_data}, {24'd0, ld});
            end
            wc_m = (wc_m == 255) ? 255 : wc_m + 1;
         end
         if (frame_err) begin
            chk("unexpected_frame_err", {31'd0, err_m == 0}, 32'd0);
            if (err_m > 0) err_m--;
         end
         chk("write_count", {24'd0, write_count}, wc_m);
         chk("hold_addr", {28'd0, cfg_addr}, {28'd0, la});
         chk("hold_data", {24'd0, cfg_data}, {24'd0, ld});
         prev_we = cfg_we;
      end
   end
   initial begin
      cyc(3);
      chk("rst_we", {31'd0, cfg_we}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, frame_err}, 32'd0);
      chk("rst_count", {24'd0, write_count}, 32'd0);
      chk("rst_addr_data", {20'd0, cfg_addr, cfg_data}, 32'd0);
      reset = 1'b0;
      cyc(5);
      frame(4'h0, 8'h80);
      chk("f0_addr", {28'd0, cfg_addr}, 32'h0);
      chk("f0_data", {24'd0, cfg_data}, 32'h80);
      chk("f0_count", {24'd0, write_count}, 32'd1);
      chk("f0_busy", {31'd0, busy}, 32'd0);
      err_m++;
      cs_n = 1'b0; cyc(3); send_bits(32'h5A, 7); cyc(3); cs_n = 1'b1; cyc(5);
      chk("abort_count", {24'd0, write_count}, 32'd1);
      chk("abort_err_seen", err_m, 32'd0);
      frame(4'h3, 8'h55);
      chk("f1_count", {24'd0, write_count}, 32'd2);
      cs_n = 1'b0; cyc(6); cs_n = 1'b1; cyc(5);
      exp_q.push_back({4'hE, 8'h11});
`ifdef SNN_CFG_AUTO_INC_EN
      exp_q.push_back({4'hF, 8'h22});
      exp_q.push_back({4'h0, 8'h33});
`endif
      cs_n = 1'b0; cyc(3); send_bits({8'h0, 4'hE, 8'h11, 8'h22, 8'h33}, 28); cyc(3); cs_n = 1'b1; cyc(5);
`ifdef SNN_CFG_AUTO_INC_EN
      chk("burst_count", {24'd0, write_count}, 32'd5);
      chk("burst_last", {20'd0, cfg_addr, cfg_data}, 32'h033);
`else
      chk("burst_count", {24'd0, write_count}, 32'd3);
      chk("burst_last", {20'd0, cfg_addr, cfg_data}, 32'hE11);
`endif
      exp_q.push_back({4'h2, 8'hAA});
`ifdef SNN_CFG_AUTO_INC_EN
      err_m++;
`endif
      cs_n = 1'b0; cyc(3); send_bits({17'd0, 4'h2, 8'hAA, 3'b101}, 15); cyc(3); cs_n = 1'b1; cyc(5);
      chk("partial_err_done", err_m, 32'd0);
      exp_q.push_back({4'h7, 8'hC3});
      cs_n = 1'b0; cyc(3); send_bits({21'd0, 4'h7, 7'h61}, 11);
      mosi = 1'b1; cyc(3); sck = 1'b1; cs_n = 1'b1; cyc(3); sck = 1'b0; cyc(5);
      chk("simul_written", exp_q.size(), 32'd0);
      exp_q.push_back({4'h9, 8'hA5});
      cs_n = 1'b0; cyc(3); send_bits({21'd0, 4'h9, 7'h52}, 11);
      chk("busy_mid_frame", {31'd0, busy}, 32'd1);
      mosi = 1'b1; cyc(3); sck = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (cfg_we) begin lat = k; break; end
      end
      chk("we_latency", lat, 32'd4);
      cyc(3); sck = 1'b0; cyc(3); cs_n = 1'b1; cyc(5);
      cs_n = 1'b0; cyc(3); send_bits(32'h2B, 6);
      reset = 1'b1; cyc(1);
      chk("midrst_count", {24'd0, write_count}, 32'd0);
      chk("midrst_we", {31'd0, cfg_we}, 32'd0);
      cyc(1); reset = 1'b0;
      send_bits(32'h1F, 5); cyc(3); cs_n = 1'b1; cyc(5);
      chk("midrst_no_write", {24'd0, write_count}, 32'd0);
      frame(4'h1, 8'h10);
      chk("post_rst_write", {20'd0, write_count[3:0], cfg_addr, cfg_data}, 32'h1110);
      for (int i = 0; i < 260; i++) frame(i[3:0], i[7:0] ^ 8'h5A);
      chk("sat_count", {24'd0, write_count}, 32'd255);
      chk("sat_last", {20'd0, cfg_addr, cfg_data}, 32'h359);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("err_pending", err_m, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
